// File: rtl/axis_packet_scheduler.sv
// Run-control gate between a free-running AXI4-Stream source and the DMA:
// passes whole packets of a runtime length, a runtime number of times, with tlast framing.
module axis_packet_scheduler #(
    parameter int TDATA_WIDTH = 64,
    parameter int LEN_WIDTH   = 32
) (
    input  logic                   aclk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   trig_en,
    input  logic                   trig,
    input  logic [LEN_WIDTH-1:0]   cfg_pkt_length,
    input  logic [31:0]            cfg_n_pkts,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                   busy,
    output logic                   done,
    output logic                   cfg_error,
    output logic [31:0]            pkt_count
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        RUN,
        STOPPING
    } state_t;

    state_t               state_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [31:0]          nPkts_q;
    logic [LEN_WIDTH-1:0] beatCnt_q;
    logic [31:0]          pktCount_q;
    logic [31:0]          pktCount_d;
    logic                 done_q;
    logic                 cfgError_q;

    logic gateOpen;
    logic hs;
    logic lastBeat;
    logic finalPkt;

    // Outside RUN/STOPPING the source is drained so it never backs up.
    assign gateOpen      = (state_q == RUN) || (state_q == STOPPING);
    assign m_axis_tvalid = gateOpen & s_axis_tvalid;
    assign s_axis_tready = gateOpen ? m_axis_tready : 1'b1;
    assign m_axis_tdata  = s_axis_tdata;

    assign hs         = gateOpen & s_axis_tvalid & m_axis_tready;
    assign lastBeat   = gateOpen && (beatCnt_q == len_q - LEN_WIDTH'(1));
    assign pktCount_d = pktCount_q + 32'd1;
    assign finalPkt   = (nPkts_q != 32'd0) && (pktCount_d == nPkts_q);

    assign m_axis_tlast = lastBeat;
    assign busy         = (state_q != IDLE);
    assign done         = done_q;
    assign cfg_error    = cfgError_q;
    assign pkt_count    = pktCount_q;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            len_q      <= '0;
            nPkts_q    <= '0;
            beatCnt_q  <= '0;
            pktCount_q <= '0;
            done_q     <= 1'b0;
            cfgError_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_pkt_length != '0) begin
                            len_q      <= cfg_pkt_length;
                            nPkts_q    <= cfg_n_pkts;
                            beatCnt_q  <= '0;
                            pktCount_q <= '0;
                            done_q     <= 1'b0;
                            cfgError_q <= 1'b0;
                            state_q    <= trig_en ? ARMED : RUN;
                        end else begin
                            cfgError_q <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (abort) begin
                        state_q <= IDLE;
                    end else if (trig) begin
                        state_q <= RUN;
                    end
                end
                RUN, STOPPING: begin
                    // A pending stop always resolves on a packet boundary, never mid-packet.
                    if (hs && lastBeat) begin
                        beatCnt_q  <= '0;
                        pktCount_q <= pktCount_d;
                        if (finalPkt) begin
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (state_q == STOPPING || abort) begin
                            state_q <= IDLE;
                        end
                    end else if (hs) begin
                        beatCnt_q <= beatCnt_q + LEN_WIDTH'(1);
                        if (state_q == RUN && abort) begin
                            state_q <= STOPPING;
                        end
                    end else if (state_q == RUN && abort) begin
                        state_q <= (beatCnt_q == '0) ? IDLE : STOPPING;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_packet_scheduler.sv
// Randomized bench for axis_packet_scheduler, compared against a beat-count reference model
// that derives framing and packet counts arithmetically from the total handshake count.
module tb_axis_packet_scheduler;

    logic        aclk;
    logic        reset;
    logic        start;
    logic        abort;
    logic        trig_en;
    logic        trig;
    logic [31:0] cfg_pkt_length;
    logic [31:0] cfg_n_pkts;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [63:0] s_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic [63:0] m_axis_tdata;
    logic        busy;
    logic        done;
    logic        cfg_error;
    logic [31:0] pkt_count;

    int nChecks;
    int nFails;

    // Reference model state: acquisition phase flags plus total handshakes since start.
    bit          mActive;
    bit          mArmed;
    bit          mStop;
    bit          mDone;
    bit          mErr;
    int unsigned mLen;
    int unsigned mN;
    int unsigned mHs;

    axis_packet_scheduler #(.TDATA_WIDTH(64), .LEN_WIDTH(32)) dut (
        .aclk           (aclk),
        .reset          (reset),
        .start          (start),
        .abort          (abort),
        .trig_en        (trig_en),
        .trig           (trig),
        .cfg_pkt_length (cfg_pkt_length),
        .cfg_n_pkts     (cfg_n_pkts),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready),
        .s_axis_tdata   (s_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .busy           (busy),
        .done           (done),
        .cfg_error      (cfg_error),
        .pkt_count      (pkt_count)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    function automatic logic [101:0] obsVec();
        return {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done, cfg_error,
                pkt_count, (mActive ? m_axis_tdata : 64'd0)};
    endfunction

    function automatic logic [101:0] expVec();
        logic        lastE;
        logic [31:0] pktE;
        lastE = mActive && ((mHs % mLen) == mLen - 1);
        pktE  = (mLen == 0) ? 32'd0 : 32'(mHs / mLen);
        return {mActive & s_axis_tvalid, lastE, (mActive ? m_axis_tready : 1'b1),
                mActive | mArmed, mDone, mErr, pktE, (mActive ? s_axis_tdata : 64'd0)};
    endfunction

    task automatic modelReset();
        mActive = 0; mArmed = 0; mStop = 0; mDone = 0; mErr = 0;
        mLen = 0; mN = 0; mHs = 0;
    endtask

    // Applies the acquisition rules to the inputs present in the cycle ending at the next edge.
    task automatic modelStep();
        bit hsNow;
        bit endPkt;
        hsNow  = 0;
        endPkt = 0;
        if (mActive) begin
            hsNow = s_axis_tvalid && m_axis_tready;
            if (hsNow) begin
                mHs++;
                endPkt = (mHs % mLen) == 0;
            end
            if (endPkt && mN != 0 && (mHs / mLen) == mN) begin
                mDone = 1; mActive = 0;
            end else if (endPkt && (mStop || abort)) begin
                mActive = 0;
            end else if (abort && !hsNow && (mHs % mLen) == 0) begin
                mActive = 0;
            end else if (abort) begin
                mStop = 1;
            end
        end else if (mArmed) begin
            if (abort) begin
                mArmed = 0;
            end else if (trig) begin
                mArmed = 0; mActive = 1;
            end
        end else if (start) begin
            if (cfg_pkt_length == 0) begin
                mErr = 1;
            end else begin
                mLen = cfg_pkt_length; mN = cfg_n_pkts; mHs = 0;
                mDone = 0; mErr = 0; mStop = 0;
                if (trig_en) mArmed = 1;
                else mActive = 1;
            end
        end
    endtask

    task automatic advance();
        modelStep();
        @(posedge aclk);
        #1;
        start = 0;
        abort = 0;
        trig  = 0;
    endtask

    task automatic issueStart(input int len, input int n, input bit te);
        start = 1; trig_en = te; cfg_pkt_length = len; cfg_n_pkts = n;
        s_axis_tdata = {$urandom, $urandom};
        #3;
        nChecks++;
        if (obsVec() !== expVec()) begin
            nFails++;
            $display("[TB] FAIL start_cycle t=%0t got=%h want=%h", $time, obsVec(), expVec());
        end
        advance();
        cfg_pkt_length = $urandom;
        cfg_n_pkts     = $urandom;
    endtask

    task automatic test_reset();
        #2;
        nChecks++;
        if (obsVec() !== expVec()) begin
            nFails++;
            $display("[TB] FAIL reset_state got=%h want=%h", obsVec(), expVec());
        end
        nChecks++;
        if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy} !== 4'b0010) begin
            nFails++;
            $display("[TB] FAIL reset_outputs got=%b want=0010",
                     {m_axis_tvalid, m_axis_tlast, s_axis_tready, busy});
        end
        @(posedge aclk);
        #1;
        reset = 0;
        advance();
    endtask

    task automatic test_basic();
        int hsSeen = 0;
        int lastSeen = 0;
        int cyc = 0;
        s_axis_tvalid = 1; m_axis_tready = 1;
        issueStart(4, 3, 0);
        while (mActive && cyc < 60) begin
            s_axis_tdata = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL basic_cycle t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            if (m_axis_tvalid && m_axis_tready) hsSeen++;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
                lastSeen++;
                nChecks++;
                if (hsSeen % 4 != 0) begin
                    nFails++;
                    $display("[TB] FAIL basic_tlast_pos got=beat%0d want=multiple of 4", hsSeen);
                end
            end
            advance();
            cyc++;
        end
        s_axis_tdata = {$urandom, $urandom};
        #3;
        nChecks++;
        if ({hsSeen[7:0], lastSeen[7:0]} !== {8'd12, 8'd3}) begin
            nFails++;
            $display("[TB] FAIL basic_counts got=%0d/%0d want=12/3", hsSeen, lastSeen);
        end
        nChecks++;
        if ({done, busy, m_axis_tvalid, pkt_count} !== {3'b100, 32'd3}) begin
            nFails++;
            $display("[TB] FAIL basic_done got=%b%b%b pkt=%0d want=100 pkt=3",
                     done, busy, m_axis_tvalid, pkt_count);
        end
        advance();
    endtask

    task automatic test_backpressure();
        int hsSeen = 0;
        int lastSeen = 0;
        int cyc = 0;
        issueStart(5, 2, 0);
        while (mActive && cyc < 400) begin
            s_axis_tvalid = ($urandom_range(0, 9) < 7);
            m_axis_tready = ($urandom_range(0, 9) < 6);
            s_axis_tdata  = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL backpressure_cycle t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            if (m_axis_tvalid && m_axis_tready) hsSeen++;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) lastSeen++;
            advance();
            cyc++;
        end
        nChecks++;
        if (mActive || hsSeen != 10 || lastSeen != 2) begin
            nFails++;
            $display("[TB] FAIL backpressure_counts got=%0d/%0d want=10/2 (timeout=%0b)",
                     hsSeen, lastSeen, mActive);
        end
        s_axis_tvalid = 1; m_axis_tready = 1;
    endtask

    task automatic test_trigger();
        int cyc = 0;
        issueStart(2, 1, 1);
        for (int i = 0; i < 21; i++) begin
            trig = (i == 20);
            s_axis_tdata = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL trigger_wait t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            advance();
        end
        s_axis_tdata = {$urandom, $urandom};
        #3;
        nChecks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== s_axis_tdata) begin
            nFails++;
            $display("[TB] FAIL trigger_first_beat got=%b want=1", m_axis_tvalid);
        end
        advance();
        while (mActive && cyc < 20) begin
            s_axis_tdata = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL trigger_run t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            advance();
            cyc++;
        end
    endtask

    task automatic test_abort_mid();
        int hsSeen = 0;
        int lastSeen = 0;
        int cyc = 0;
        issueStart(8, 0, 0);
        while (mActive && cyc < 100) begin
            abort = (mHs == 10);
            s_axis_tdata = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL abort_mid_cycle t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            if (m_axis_tvalid && m_axis_tready) hsSeen++;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) lastSeen++;
            advance();
            cyc++;
        end
        #3;
        nChecks++;
        if (hsSeen != 16 || lastSeen != 2 || {busy, done, pkt_count} !== {2'b00, 32'd2}) begin
            nFails++;
            $display("[TB] FAIL abort_mid got=hs%0d last%0d busy%b done%b pkt%0d want=hs16 last2 busy0 done0 pkt2",
                     hsSeen, lastSeen, busy, done, pkt_count);
        end
        advance();
    endtask

    task automatic test_abort_last();
        int cyc = 0;
        issueStart(3, 0, 0);
        while (mActive && cyc < 40) begin
            abort = (mHs == 5);
            s_axis_tdata = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL abort_last_cycle t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            advance();
            cyc++;
        end
        #3;
        nChecks++;
        if (cyc != 6 || {busy, pkt_count} !== {1'b0, 32'd2}) begin
            nFails++;
            $display("[TB] FAIL abort_last got=cyc%0d busy%b pkt%0d want=cyc6 busy0 pkt2", cyc, busy, pkt_count);
        end
        advance();
    endtask

    task automatic test_len_zero();
        issueStart(0, 4, 0);
        #3;
        nChecks++;
        if ({cfg_error, busy, m_axis_tvalid} !== 3'b100) begin
            nFails++;
            $display("[TB] FAIL len_zero got=err%b busy%b tvalid%b want=err1 busy0 tvalid0",
                     cfg_error, busy, m_axis_tvalid);
        end
        advance();
    endtask

    task automatic test_len_one();
        int hsSeen = 0;
        int lastSeen = 0;
        int cyc = 0;
        issueStart(1, 5, 0);
        while (mActive && cyc < 100) begin
            s_axis_tvalid = $urandom_range(0, 1);
            s_axis_tdata  = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL len_one_cycle t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            if (m_axis_tvalid && m_axis_tready) hsSeen++;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast) lastSeen++;
            advance();
            cyc++;
        end
        nChecks++;
        if (hsSeen != 5 || lastSeen != 5 || done !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL len_one got=hs%0d last%0d done%b want=hs5 last5 done1", hsSeen, lastSeen, done);
        end
        s_axis_tvalid = 1;
    endtask

    task automatic test_reset_midrun();
        int cyc = 0;
        issueStart(4, 0, 0);
        for (int i = 0; i < 6; i++) begin
            s_axis_tdata = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL reset_midrun_cycle t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            advance();
        end
        #3;
        reset = 1;
        modelReset();
        #1;
        nChecks++;
        if ({m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done, pkt_count} !== {5'b00100, 32'd0}) begin
            nFails++;
            $display("[TB] FAIL reset_async got=%b%b%b%b%b pkt%0d want=00100 pkt0",
                     m_axis_tvalid, m_axis_tlast, s_axis_tready, busy, done, pkt_count);
        end
        @(posedge aclk);
        #1;
        reset = 0;
        issueStart(2, 2, 0);
        while (mActive && cyc < 20) begin
            s_axis_tdata = {$urandom, $urandom};
            #3;
            nChecks++;
            if (obsVec() !== expVec()) begin
                nFails++;
                $display("[TB] FAIL reset_restart t=%0t got=%h want=%h", $time, obsVec(), expVec());
            end
            advance();
            cyc++;
        end
        #3;
        nChecks++;
        if ({done, busy, pkt_count} !== {2'b10, 32'd2}) begin
            nFails++;
            $display("[TB] FAIL reset_restart_done got=done%b busy%b pkt%0d want=done1 busy0 pkt2",
                     done, busy, pkt_count);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        reset = 1; start = 0; abort = 0; trig_en = 0; trig = 0;
        cfg_pkt_length = 0; cfg_n_pkts = 0;
        s_axis_tvalid = 0; s_axis_tdata = '0; m_axis_tready = 1;
        modelReset();
        test_reset();
        test_basic();
        test_backpressure();
        test_trigger();
        test_abort_mid();
        test_abort_last();
        test_len_zero();
        test_len_one();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
